// File: rtl/sample_ram_write_ctrl_pkg.sv
// Shared types and constants for the sample RAM write-side controller.
package sample_ram_write_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int BLK_W  = 4;
  localparam int CNT_W  = BLK_W + 1;

  typedef logic [63:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POST,
    DONE
  } state_t;

endpackage

// File: rtl/sample_ram_write_ctrl_occupancy.sv
// Tracks how many RAM blocks hold completed captures awaiting readout.
module sample_block_occupancy
  import sample_ram_write_ctrl_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_done,
  input  logic i_release,
  output logic o_full
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countNext;
  logic             w_releaseOk;
  logic             r_full;

  // A release against an empty pool is meaningless, so it never underflows.
  assign w_releaseOk = i_release && (r_count != '0);

  always_comb begin
    w_countNext = r_count;
    if (i_done && !w_releaseOk) begin
      w_countNext = r_count + 1'b1;
    end else if (!i_done && w_releaseOk) begin
      w_countNext = r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_count <= w_countNext;
      r_full  <= (w_countNext == CNT_W'(NUM_BLOCKS));
    end
  end

  assign o_full = r_full;

endmodule

// File: rtl/sample_ram_write_ctrl.sv
// Pre/post-trigger capture into rotating RAM blocks; define
// SAMPLE_WRITE_TEST_PATTERN_EN to write a counting pattern instead of samples.
module sample_ram_write_ctrl
  import sample_ram_write_ctrl_pkg::*;
#(
  parameter int NUM_BLOCKS      = 8,
  parameter int WORDS_PER_BLOCK = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        Enable,
  input  logic [63:0] Sample_Data,
  input  logic        Sample_Valid,
  input  logic        Trigger,
  input  logic [15:0] Pre_Trigger_Len,
  input  logic [15:0] Post_Trigger_Len,
  input  logic        Block_Release,
  output logic [15:0] A_ADDR,
  output logic [3:0]  A_Block_Address_vector,
  output logic [63:0] A_DIN,
  output logic        A_WEN,
  output logic        Block_Done,
  output logic [3:0]  Done_Block_Addr,
  output logic [15:0] Trigger_Addr,
  output logic        Full,
  output logic        Busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_BLOCK - 1);
  localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(NUM_BLOCKS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pre;
  logic [ADDR_W-1:0] r_post;
  logic [ADDR_W-1:0] r_preCnt;
  logic [ADDR_W-1:0] r_postCnt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_trigLatch;
  logic [BLK_W-1:0]  r_blkPtr;
  logic [ADDR_W-1:0] r_aAddr;
  logic [BLK_W-1:0]  r_aBlk;
  sample_t           r_din;
  logic              r_wen;
  logic              r_blockDone;
  logic [BLK_W-1:0]  r_doneBlk;
  logic [ADDR_W-1:0] r_trigAddr;
  logic              r_busy;

  logic              w_full;
  logic [ADDR_W-1:0] w_preClamp;
  logic [ADDR_W-1:0] w_postMax;
  logic [ADDR_W-1:0] w_postClamp;
  logic [ADDR_W-1:0] w_addrInc;
  logic [ADDR_W-1:0] w_preCntInc;
  logic [ADDR_W-1:0] w_postCntInc;
  logic              w_active;
  logic              w_write;
  logic              w_start;

  // Pre and post together must fit in one block alongside the trigger word.
  assign w_preClamp   = (Pre_Trigger_Len > LAST_ADDR) ? LAST_ADDR : Pre_Trigger_Len;
  assign w_postMax    = LAST_ADDR - w_preClamp;
  assign w_postClamp  = (Post_Trigger_Len > w_postMax) ? w_postMax : Post_Trigger_Len;
  assign w_addrInc    = (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
  assign w_preCntInc  = r_preCnt + 1'b1;
  assign w_postCntInc = r_postCnt + 1'b1;
  assign w_active     = (r_state == PRETRIG) || (r_state == ARMED) || (r_state == POST);
  assign w_write      = w_active && Enable && Sample_Valid;
  // Occupancy lags Block_Done by a cycle, so hold off a new capture until it settles.
  assign w_start      = (r_state == IDLE) && Enable && !w_full && !r_blockDone;

`ifdef SAMPLE_WRITE_TEST_PATTERN_EN
  logic [ADDR_W-1:0] r_patCnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wen    <= 1'b0;
      r_aAddr  <= '0;
      r_aBlk   <= '0;
      r_din    <= '0;
      r_patCnt <= '0;
    end else begin
      r_wen <= w_write;
      if (w_write) begin
        r_aAddr  <= r_addr;
        r_aBlk   <= r_blkPtr;
        r_din    <= {{(64-ADDR_W){1'b0}}, r_patCnt};
        r_patCnt <= r_patCnt + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wen   <= 1'b0;
      r_aAddr <= '0;
      r_aBlk  <= '0;
      r_din   <= '0;
    end else begin
      r_wen <= w_write;
      if (w_write) begin
        r_aAddr <= r_addr;
        r_aBlk  <= r_blkPtr;
        r_din   <= Sample_Data;
      end
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_pre       <= '0;
      r_post      <= '0;
      r_preCnt    <= '0;
      r_postCnt   <= '0;
      r_addr      <= '0;
      r_trigLatch <= '0;
      r_blkPtr    <= '0;
      r_blockDone <= 1'b0;
      r_doneBlk   <= '0;
      r_trigAddr  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_blockDone <= 1'b0;
      if (w_write) begin
        r_addr <= w_addrInc;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_pre    <= w_preClamp;
            r_post   <= w_postClamp;
            r_addr   <= '0;
            r_preCnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= (w_preClamp == '0) ? ARMED : PRETRIG;
          end
        end
        PRETRIG: begin
          if (!Enable) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (Sample_Valid) begin
            r_preCnt <= w_preCntInc;
            if (w_preCntInc == r_pre) begin
              r_state <= ARMED;
            end
          end
        end
        ARMED: begin
          if (!Enable) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (Sample_Valid && Trigger) begin
            r_trigLatch <= r_addr;
            r_postCnt   <= '0;
            r_state     <= (r_post == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (!Enable) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (Sample_Valid) begin
            r_postCnt <= w_postCntInc;
            if (w_postCntInc == r_post) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_blockDone <= 1'b1;
          r_doneBlk   <= r_blkPtr;
          r_trigAddr  <= r_trigLatch;
          r_blkPtr    <= (r_blkPtr == LAST_BLK) ? '0 : r_blkPtr + 1'b1;
          r_state     <= IDLE;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  sample_block_occupancy #(
    .NUM_BLOCKS(NUM_BLOCKS)
  ) u_occupancy (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_done   (r_blockDone),
    .i_release(Block_Release),
    .o_full   (w_full)
  );

  assign A_ADDR                 = r_aAddr;
  assign A_Block_Address_vector = r_aBlk;
  assign A_DIN                  = r_din;
  assign A_WEN                  = r_wen;
  assign Block_Done             = r_blockDone;
  assign Done_Block_Addr        = r_doneBlk;
  assign Trigger_Addr           = r_trigAddr;
  assign Full                   = w_full;
  assign Busy                   = r_busy;

endmodule

// File: tb/tb_sample_ram_write_ctrl.sv
// Scoreboard bench for sample_ram_write_ctrl: a 1024-word instance for most
// scenarios and a 16-word instance for the address-wrap scenario.
module tb_sample_ram_write_ctrl;

  localparam int NB = 8;

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  blk;
    logic [63:0] din;
  } wrExp_t;

  typedef struct {
    logic [3:0]  blk;
    logic [15:0] trig;
  } doneExp_t;

  typedef struct {
    int          pre;
    int          post;
    int          nBefore;
    bit          gaps;
    logic [15:0] expTrig;
    int          expWrites;
    logic [15:0] expLastAddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, sampleValid, trigger, blockRelease;
  logic [63:0] sampleData;
  logic [15:0] preLen, postLen;
  logic        useSmall;

  logic [15:0] aAddrL, aAddrS, trigAddrL, trigAddrS;
  logic [3:0]  blkL, blkS, doneBlkL, doneBlkS;
  logic [63:0] dinL, dinS;
  logic        wenL, wenS, doneL, doneS, fullL, fullS, busyL, busyS;

  logic [15:0] mAddr, mTrig;
  logic [3:0]  mBlk, mDoneBlk;
  logic [63:0] mDin;
  logic        mWen, mDone, mFull, mBusy;

  wrExp_t   wrQ[$];
  doneExp_t doneQ[$];
  wrExp_t   monWr;
  doneExp_t monDn;
  vec_t     vecs[5];
  int       checks = 0;
  int       errors = 0;
  int       wrCount = 0;
  int       expBlk = 0;
`ifdef SAMPLE_WRITE_TEST_PATTERN_EN
  logic [15:0] patCnt = '0;
`endif

  always #5 clk = ~clk;

  sample_ram_write_ctrl #(.NUM_BLOCKS(NB), .WORDS_PER_BLOCK(1024)) dutLarge (
    .i_clk(clk), .i_rst(rst), .Enable(enable), .Sample_Data(sampleData),
    .Sample_Valid(sampleValid), .Trigger(trigger), .Pre_Trigger_Len(preLen),
    .Post_Trigger_Len(postLen), .Block_Release(blockRelease), .A_ADDR(aAddrL),
    .A_Block_Address_vector(blkL), .A_DIN(dinL), .A_WEN(wenL), .Block_Done(doneL),
    .Done_Block_Addr(doneBlkL), .Trigger_Addr(trigAddrL), .Full(fullL), .Busy(busyL)
  );

  sample_ram_write_ctrl #(.NUM_BLOCKS(NB), .WORDS_PER_BLOCK(16)) dutSmall (
    .i_clk(clk), .i_rst(rst), .Enable(enable), .Sample_Data(sampleData),
    .Sample_Valid(sampleValid), .Trigger(trigger), .Pre_Trigger_Len(preLen),
    .Post_Trigger_Len(postLen), .Block_Release(blockRelease), .A_ADDR(aAddrS),
    .A_Block_Address_vector(blkS), .A_DIN(dinS), .A_WEN(wenS), .Block_Done(doneS),
    .Done_Block_Addr(doneBlkS), .Trigger_Addr(trigAddrS), .Full(fullS), .Busy(busyS)
  );

  assign mAddr    = useSmall ? aAddrS : aAddrL;
  assign mTrig    = useSmall ? trigAddrS : trigAddrL;
  assign mBlk     = useSmall ? blkS : blkL;
  assign mDoneBlk = useSmall ? doneBlkS : doneBlkL;
  assign mDin     = useSmall ? dinS : dinL;
  assign mWen     = useSmall ? wenS : wenL;
  assign mDone    = useSmall ? doneS : doneL;
  assign mFull    = useSmall ? fullS : fullL;
  assign mBusy    = useSmall ? busyS : busyL;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Every write and every completed block is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mWen) begin
        wrCount++;
        if (wrQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedWrite actual A_WEN=1 A_ADDR=%0d expected A_WEN=0", mAddr);
        end else begin
          monWr = wrQ.pop_front();
          checkOutput("A_ADDR", {48'h0, mAddr}, {48'h0, monWr.addr});
          checkOutput("A_Block_Address_vector", {60'h0, mBlk}, {60'h0, monWr.blk});
          checkOutput("A_DIN", mDin, monWr.din);
        end
      end
      if (mDone) begin
        if (doneQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedDone actual Block_Done=1 expected Block_Done=0");
        end else begin
          monDn = doneQ.pop_front();
          checkOutput("Done_Block_Addr", {60'h0, mDoneBlk}, {60'h0, monDn.blk});
          checkOutput("Trigger_Addr", {48'h0, mTrig}, {48'h0, monDn.trig});
        end
      end
    end
  end

  task automatic pushWrite(input int addr, input logic [63:0] data);
    wrExp_t e;
    e.addr = 16'(addr);
    e.blk  = 4'(expBlk);
`ifdef SAMPLE_WRITE_TEST_PATTERN_EN
    e.din  = {48'h0, patCnt};
    patCnt = patCnt + 16'd1;
`else
    e.din  = data;
`endif
    wrQ.push_back(e);
  endtask

  // One full capture: nBefore untriggered samples, the trigger, then the post words.
  task automatic applyStimulus(input int pre, input int post, input int nBefore, input bit gaps,
                               input bit relWithDone, input logic [15:0] expTrig);
    int W, pc, qc, total;
    bit seen;
    doneExp_t d;
    W  = useSmall ? 16 : 1024;
    pc = (pre > W - 1) ? W - 1 : pre;
    qc = (post > W - 1 - pc) ? W - 1 - pc : post;
    total = nBefore + 1 + qc;
    preLen = 16'(pre);
    postLen = 16'(post);
    enable = 1'b1;
    sampleValid = 1'b0;
    trigger = 1'b0;
    @(negedge clk);
    checkOutput("busyAfterStart", {63'h0, mBusy}, 64'h1);
    for (int k = 0; k < total; k++) begin
      if (gaps && (k % 3 == 2)) begin
        sampleValid = 1'b0;
        @(negedge clk);
      end
      sampleData = {$urandom, $urandom};
      trigger = (k == nBefore) || (k == 0 && pc > 0) || (k > nBefore && $urandom_range(0, 1) == 1);
      sampleValid = 1'b1;
      pushWrite(k % W, sampleData);
      @(negedge clk);
    end
    sampleValid = 1'b0;
    trigger = 1'b0;
    enable = 1'b0;
    d.blk = 4'(expBlk);
    d.trig = expTrig;
    doneQ.push_back(d);
    expBlk = (expBlk + 1) % NB;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (mDone) begin
        seen = 1'b1;
        if (relWithDone) blockRelease = 1'b1;
      end
      @(negedge clk);
      blockRelease = 1'b0;
    end
    checkOutput("blockDoneSeen", {63'h0, seen}, 64'h1);
    @(negedge clk);
  endtask

  task automatic pulseRelease(input int n);
    for (int i = 0; i < n; i++) begin
      blockRelease = 1'b1;
      @(negedge clk);
      blockRelease = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wrQ.delete();
    doneQ.delete();
    expBlk = 0;
`ifdef SAMPLE_WRITE_TEST_PATTERN_EN
    patCnt = '0;
`endif
    @(negedge clk);
  endtask

  initial begin
    int startCount;
    rst = 1'b1;
    enable = 1'b0;
    sampleValid = 1'b0;
    trigger = 1'b0;
    blockRelease = 1'b0;
    sampleData = '0;
    preLen = '0;
    postLen = '0;
    useSmall = 1'b0;

    vecs[0] = '{pre: 4,    post: 3,    nBefore: 9,    gaps: 1'b0, expTrig: 16'd9,    expWrites: 13,   expLastAddr: 16'd12};
    vecs[1] = '{pre: 0,    post: 0,    nBefore: 0,    gaps: 1'b0, expTrig: 16'd0,    expWrites: 1,    expLastAddr: 16'd0};
    vecs[2] = '{pre: 1000, post: 1000, nBefore: 1000, gaps: 1'b0, expTrig: 16'd1000, expWrites: 1024, expLastAddr: 16'd1023};
    vecs[3] = '{pre: 2,    post: 5,    nBefore: 7,    gaps: 1'b1, expTrig: 16'd7,    expWrites: 13,   expLastAddr: 16'd12};
    vecs[4] = '{pre: 5000, post: 7,    nBefore: 1023, gaps: 1'b0, expTrig: 16'd1023, expWrites: 1024, expLastAddr: 16'd1023};

    repeat (2) @(negedge clk);
    checkOutput("rstA_ADDR", {48'h0, aAddrL}, 64'h0);
    checkOutput("rstA_DIN", dinL, 64'h0);
    checkOutput("rstA_WEN", {63'h0, wenL}, 64'h0);
    checkOutput("rstBlock", {60'h0, blkL}, 64'h0);
    checkOutput("rstBlock_Done", {63'h0, doneL}, 64'h0);
    checkOutput("rstTrigger_Addr", {48'h0, trigAddrL}, 64'h0);
    checkOutput("rstFull", {63'h0, fullL}, 64'h0);
    checkOutput("rstBusy", {63'h0, busyL}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Address wrap in ARMED on the 16-word instance.
    useSmall = 1'b1;
    startCount = wrCount;
    applyStimulus(2, 3, 20, 1'b0, 1'b0, 16'd4);
    checkOutput("wrapWrites", 64'(wrCount - startCount), 64'd24);
    checkOutput("wrapLastAddr", {48'h0, mAddr}, 64'd7);
    applyReset();
    useSmall = 1'b0;

    for (int i = 0; i < 5; i++) begin
      startCount = wrCount;
      applyStimulus(vecs[i].pre, vecs[i].post, vecs[i].nBefore, vecs[i].gaps, 1'b0, vecs[i].expTrig);
      checkOutput($sformatf("vec%0dWrites", i), 64'(wrCount - startCount), 64'(vecs[i].expWrites));
      checkOutput($sformatf("vec%0dLastAddr", i), {48'h0, mAddr}, {48'h0, vecs[i].expLastAddr});
    end

    // Abort in POST: no completion, same block restarts at address 0.
    preLen = 16'd2;
    postLen = 16'd5;
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      sampleData = {$urandom, $urandom};
      trigger = (k == 3);
      sampleValid = 1'b1;
      pushWrite(k, sampleData);
      @(negedge clk);
    end
    sampleValid = 1'b0;
    trigger = 1'b0;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("busyAfterAbort", {63'h0, mBusy}, 64'h0);
    applyStimulus(3, 2, 4, 1'b0, 1'b0, 16'd4);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 2, 1'b0, 1'b0, 16'd2);
      checkOutput($sformatf("fillFull%0d", i), {63'h0, mFull}, {63'h0, (i == 1)});
    end

    // Full stalls capture: samples are dropped.
    preLen = 16'd0;
    postLen = 16'd0;
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sampleValid = 1'b1;
      trigger = 1'b1;
      sampleData = {$urandom, $urandom};
      @(negedge clk);
    end
    sampleValid = 1'b0;
    trigger = 1'b0;
    checkOutput("busyWhileFull", {63'h0, mBusy}, 64'h0);
    enable = 1'b0;
    @(negedge clk);

    pulseRelease(1);
    checkOutput("fullAfterRelease", {63'h0, mFull}, 64'h0);
    applyStimulus(4, 3, 9, 1'b0, 1'b0, 16'd9);
    checkOutput("fullAgain", {63'h0, mFull}, 64'h1);

    // Count to 3, then a release coincident with Block_Done must leave it at 3.
    pulseRelease(5);
    applyStimulus(1, 2, 3, 1'b0, 1'b1, 16'd3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 1, 1'b0, 1'b0, 16'd1);
      checkOutput($sformatf("coincidentFull%0d", i), {63'h0, mFull}, {63'h0, (i == 4)});
    end
    checkOutput("wrQueueDrained", 64'(wrQ.size()), 64'h0);
    checkOutput("doneQueueDrained", 64'(doneQ.size()), 64'h0);

    // Asynchronous reset in the middle of a capture.
    pulseRelease(1);
    preLen = 16'd3;
    postLen = 16'd4;
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      sampleData = {$urandom, $urandom};
      sampleValid = 1'b1;
      pushWrite(k, sampleData);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    checkOutput("wenBeforeRst", {63'h0, mWen}, 64'h1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstA_WEN", {63'h0, mWen}, 64'h0);
    checkOutput("asyncRstA_ADDR", {48'h0, mAddr}, 64'h0);
    checkOutput("asyncRstA_DIN", mDin, 64'h0);
    checkOutput("asyncRstBusy", {63'h0, mBusy}, 64'h0);
    checkOutput("asyncRstBlock", {60'h0, mBlk}, 64'h0);
    sampleValid = 1'b0;
    enable = 1'b0;
    applyReset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
